sub_abs_tube_scan: RTL

- Captures two unsigned WIDTH-bit operands on a sample strobe and computes the sign and absolute value of a-b.
- Converts the magnitude to BCD iteratively (shift-add-3, one bit per cycle).
- Drives a 4-digit time-multiplexed seven-segment display: sign tube plus three decimal digits.
- Parametrised, clocked successor of the combinational 3-bit sign/absolute tube decoder; sits between the switch inputs and the board tubes.

---
 rtl/sub_abs_tube_scan_if.sv | 25 ++
 rtl/sub_abs_tube_scan.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sub_abs_tube_scan_if.sv
// Operand capture / result / tube bus between the switch-side logic and the
// signed-absolute tube scanner.
interface sub_abs_tube_scan_if #(
    parameter int WIDTH = 3
);
    logic             sample;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             neg;
    logic [WIDTH-1:0] mag;
    logic [3:0]       tub_sel;
    logic [7:0]       tub_control;

    modport master (
        output sample, a, b,
        input  busy, done, neg, mag, tub_sel, tub_control
    );

    modport slave (
        input  sample, a, b,
        output busy, done, neg, mag, tub_sel, tub_control
    );
endinterface

// File: rtl/sub_abs_tube_scan.sv
// Sign/|a-b| of two captured operands, iterative BCD conversion and a
// 4-tube multiplexed seven-segment display (sign, hundreds, tens, units).
module sub_abs_tube_scan #(
    parameter int WIDTH    = 3,
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    sub_abs_tube_scan_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t            r_state;
    logic [WIDTH+11:0] r_sh;        // {bcd[11:0], binary} double-dabble shifter
    logic [SW-1:0]     r_step;
    logic              r_neg_new;
    logic [WIDTH-1:0]  r_mag_new;
    logic              r_busy;
    logic              r_done;
    logic              r_neg;
    logic [WIDTH-1:0]  r_mag;
    logic              r_disp_sign;
    logic [11:0]       r_disp_bcd;
    logic [PW-1:0]     r_prescale;
    logic [1:0]        r_idx;
    logic [3:0]        r_tub_sel;
    logic [7:0]        r_tub_control;

    logic [WIDTH:0]    w_diff;
    logic              w_lt;
    logic [WIDTH-1:0]  w_abs;
    logic [11:0]       w_bcd_adj;
    logic              w_wrap;
    logic [1:0]        w_next_idx;
    logic [7:0]        w_seg_next;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hFC;
            4'd1:    return 8'h60;
            4'd2:    return 8'hDA;
            4'd3:    return 8'hF2;
            4'd4:    return 8'h66;
            4'd5:    return 8'hB6;
            4'd6:    return 8'hBE;
            4'd7:    return 8'hE0;
            4'd8:    return 8'hFE;
            4'd9:    return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_lt   = w_diff[WIDTH];
    assign w_abs  = w_lt ? (~w_diff[WIDTH-1:0] + WIDTH'(1)) : w_diff[WIDTH-1:0];

    always_comb begin
        w_bcd_adj = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            w_bcd_adj[4*i +: 4] = (r_sh[WIDTH + 4*i +: 4] >= 4'd5) ?
                                  r_sh[WIDTH + 4*i +: 4] + 4'd3 :
                                  r_sh[WIDTH + 4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sh        <= '0;
            r_step      <= '0;
            r_neg_new   <= 1'b0;
            r_mag_new   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_neg       <= 1'b0;
            r_mag       <= '0;
            r_disp_sign <= 1'b0;
            r_disp_bcd  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.sample) begin
                        r_neg_new <= w_lt;
                        r_mag_new <= w_abs;
                        r_sh      <= {12'h000, w_abs};
                        r_step    <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_sh   <= {w_bcd_adj, r_sh[WIDTH-1:0]} << 1;
                    r_step <= r_step + SW'(1);
                    if (r_step == SW'(WIDTH - 1)) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_neg       <= r_neg_new;
                    r_mag       <= r_mag_new;
                    r_disp_sign <= r_neg_new;
                    r_disp_bcd  <= r_sh[WIDTH+11:WIDTH];
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_wrap     = (r_prescale == PW'(SCAN_DIV - 1));
    assign w_next_idx = w_wrap ? r_idx + 2'd1 : r_idx;

    // Segments follow the slot being entered, so tub_sel and tub_control move together.
    always_comb begin
        w_seg_next = 8'h00;
        case (w_next_idx)
            2'd0: w_seg_next = seg7(r_disp_bcd[3:0]);
            2'd1: w_seg_next = (BLANK_LZ && r_disp_bcd[11:4] == 8'h00) ? 8'h00
                                                                      : seg7(r_disp_bcd[7:4]);
            2'd2: w_seg_next = (BLANK_LZ && r_disp_bcd[11:8] == 4'h0) ? 8'h00
                                                                     : seg7(r_disp_bcd[11:8]);
            2'd3: w_seg_next = r_disp_sign ? 8'h02 : 8'h00;
            default: w_seg_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale    <= '0;
            r_idx         <= 2'd0;
            r_tub_sel     <= 4'b0001;
            r_tub_control <= 8'hFC;
        end else begin
            r_prescale    <= w_wrap ? '0 : r_prescale + PW'(1);
            r_idx         <= w_next_idx;
            r_tub_sel     <= 4'b0001 << w_next_idx;
            r_tub_control <= w_seg_next;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.neg         = r_neg;
    assign bus.mag         = r_mag;
    assign bus.tub_sel     = r_tub_sel;
    assign bus.tub_control = r_tub_control;
endmodule
